corner_locator: RTL and testbench
=================================

# corner_locator

Frame-level controller that sits after the per-pixel `corner_detect` colour classifier in the video path. It consumes the raster pixel stream, including each pixel's `corner_detected` flag and its (x, y) coordinate. Across each frame it tracks the four extreme detected pixels: top-left, top-right, bottom-left and bottom-right. At end of frame it publishes one coherent corner set to the downstream geometry/warp logic.

## Interface
Parameters:
- `XW`, 10: x coordinate width
- `YW`, 10: y coordinate width
- `CNT_W`, 19: detected-pixel counter width (covers 640×480)
- `MIN_PIXELS`, 16: minimum detected pixels per frame for a valid corner set

Ports:
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `frame_start`  in  1  one-cycle pulse marking the first cycle of a frame
- `frame_end`  in  1  one-cycle pulse marking the last cycle of a frame
- `pixel_valid`  in  1  x/y/corner_detected are meaningful this cycle
- `x`  in  XW  pixel column
- `y`  in  YW  pixel row
- `corner_detected`  in  1  classifier hit for this pixel
- `tl_x`, `tr_x`, `bl_x`, `br_x`  out  XW each  corner columns
- `tl_y`, `tr_y`, `bl_y`, `br_y`  out  YW each  corner rows
- `corners_found`  out  1  last published frame had ≥ MIN_PIXELS hits
- `corners_valid`  out  1  one-cycle pulse when outputs update
- `busy`  out  1  high while accumulating a frame

## Operation
- Input stage: all inputs are registered once; every decision below uses the registered copies.
- A pixel counts as a hit when `pixel_valid && corner_detected` and the FSM is in ACCUM, or a `frame_start` is registered the same cycle.
- Corner metrics:
  - TL minimises s = x+y (unsigned, XW+1 bits).
  - BR maximises s.
  - TR maximises d = x−y (signed, XW+1 bits, operands zero-extended).
  - BL minimises d.
- Comparisons are strict, so ties keep the first hit in raster order.
- The first hit of a frame unconditionally loads all four trackers.
- `hit_cnt` increments per hit and saturates at 2^CNT_W−1.
- FSM states:
  - IDLE: `busy`=0; pixels are ignored. `frame_start` → ACCUM.
  - ACCUM: `busy`=1; trackers and count update on hits.
    - `frame_end` → PUBLISH.
    - `frame_start` (without `frame_end`) clears the trackers and count, then stays in ACCUM. The new frame restarts and no publish occurs.
  - PUBLISH: one cycle, then → IDLE.
    - If `hit_cnt` ≥ MIN_PIXELS: load all eight coordinate outputs from the trackers and set `corners_found`=1.
    - Otherwise: coordinate outputs hold their previous values and `corners_found`=0.
    - In both cases `corners_valid`=1 for this cycle.
- Simultaneous events:
  - `frame_start` + `pixel_valid`: the clear happens first and the pixel counts toward the new frame.
  - `frame_end` + hit: the pixel is included before publish.
  - `frame_start` + `frame_end` in one cycle: treated as a one-pixel frame. Clear, count that pixel, then go to PUBLISH.
  - `frame_end` seen in IDLE: ignored.
  - `frame_start` arriving during PUBLISH: the publish completes and the FSM enters ACCUM on the next cycle with cleared trackers. That start is held in a one-bit pending flag so it is not lost.
- Reset, including mid-frame: FSM → IDLE, trackers and count cleared, pending flag cleared. Outputs are all zero: coordinates 0, `corners_found`=0, `corners_valid`=0, `busy`=0.

## Timing
- Input register: 1 cycle.
- Tracker update: registered one cycle after the input register.
- `corners_valid` asserts exactly 2 cycles after the `frame_end` input cycle. Coordinate outputs change on that same edge and are stable until the next publish or reset.
- Throughput: one pixel per clock, no backpressure.
- Minimum frame gap: 2 cycles from `frame_end` to the next `frame_start`. A shorter gap is handled by the pending flag.

## Structure
- Package `corner_pkg` holds:
  - FSM state enum (IDLE, ACCUM, PUBLISH)
  - corner index constants (TL, TR, BL, BR)
  - default XW/YW/CNT_W localparams
  - `corner_t` struct {x, y}
- Sub-module `corner_extreme_tracker`:
  - parameter MODE selects min/max on sum/diff
  - holds best metric + coordinate, with `clear`, `hit`, `load_first` inputs
  - instantiated 4 times.

## Test plan
- Single hit at (100,50) with MIN_PIXELS=1 → all four corners = (100,50), `corners_valid` 2 cycles after `frame_end`, `corners_found`=1.
- Filled square, x 200–299 × y 100–199 → TL (200,100), TR (299,100), BL (200,199), BR (299,199); `corners_found`=1.
- Frame with 5 hits (< 16) after a good frame → coordinates unchanged, `corners_found`=0, `corners_valid` pulses.
- Tie: hits at (10,20) then (20,10), both with s=30 → TL = (10,20), the first seen.
- Second `frame_start` mid-frame after hits at (5,5) → (5,5) discarded; published corners come only from post-restart hits.
- `reset` asserted mid-ACCUM then a new full frame → outputs zero after reset, then the correct corners for the new frame with no stale data; `busy`=0 during reset.

Source files
------------

// File: rtl/corner_pkg.sv
// Shared types and constants for the frame-level corner locator.
// Holds FSM states, corner indices, default widths and the corner coordinate struct.
package corner_pkg;

  localparam int DEF_XW    = 10;
  localparam int DEF_YW    = 10;
  localparam int DEF_CNT_W = 19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_PUBLISH
  } state_e;

  localparam int TL        = 0;
  localparam int TR        = 1;
  localparam int BL        = 2;
  localparam int BR        = 3;
  localparam int N_CORNERS = 4;

  // Extreme each tracker hunts for: s = x+y, d = x-y.
  typedef enum logic [1:0] {
    MIN_SUM,
    MAX_SUM,
    MAX_DIFF,
    MIN_DIFF
  } metric_mode_e;

  typedef struct packed {
    logic [DEF_XW-1:0] x;
    logic [DEF_YW-1:0] y;
  } corner_t;

  function automatic metric_mode_e corner_mode(input int idx);
    case (idx)
      TL:      return MIN_SUM;
      TR:      return MAX_DIFF;
      BL:      return MIN_DIFF;
      default: return MAX_SUM;
    endcase
  endfunction

endpackage

// File: rtl/corner_extreme_tracker.sv
// Tracks the pixel with the most extreme sum or difference metric within a frame.
// Strict comparison keeps the earliest pixel in raster order on ties.
module corner_extreme_tracker
  import corner_pkg::*;
#(
  parameter metric_mode_e MODE = MIN_SUM,
  parameter int           XW   = DEF_XW,
  parameter int           YW   = DEF_YW
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_hit,
  input  logic          i_load_first,
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y
);

  localparam int MW = ((XW > YW) ? XW : YW) + 1;

  logic [MW-1:0] r_best;
  logic [MW-1:0] w_metric;
  logic          w_better;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    w_metric = '0;
    w_better = 1'b0;
    if (MODE == MIN_SUM || MODE == MAX_SUM) w_metric = MW'(i_x) + MW'(i_y);
    else                                    w_metric = MW'(i_x) - MW'(i_y);
    case (MODE)
      MIN_SUM:  w_better = w_metric < r_best;
      MAX_SUM:  w_better = w_metric > r_best;
      MAX_DIFF: w_better = $signed(w_metric) > $signed(r_best);
      default:  w_better = $signed(w_metric) < $signed(r_best);
    endcase
  end

  // NOTE: non-blocking assignments so all state samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_best <= '0;
      o_x    <= '0;
      o_y    <= '0;
    end else if (i_load_first || (i_hit && w_better)) begin
      r_best <= w_metric;
      o_x    <= i_x;
      o_y    <= i_y;
    end else if (i_clear) begin
      r_best <= '0;
      o_x    <= '0;
      o_y    <= '0;
    end
  end

endmodule

// File: rtl/corner_locator.sv
// Frame-level controller: accumulates the four extreme detected pixels per frame
// and publishes one coherent corner set two cycles after frame_end.
module corner_locator
  import corner_pkg::*;
#(
  parameter int XW         = DEF_XW,
  parameter int YW         = DEF_YW,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MIN_PIXELS = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          frame_end,
  input  logic          pixel_valid,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic          corner_detected,
  output logic [XW-1:0] tl_x,
  output logic [XW-1:0] tr_x,
  output logic [XW-1:0] bl_x,
  output logic [XW-1:0] br_x,
  output logic [YW-1:0] tl_y,
  output logic [YW-1:0] tr_y,
  output logic [YW-1:0] bl_y,
  output logic [YW-1:0] br_y,
  output logic          corners_found,
  output logic          corners_valid,
  output logic          busy
);

  logic          r_fs, r_fe, r_pv, r_cd;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs <= 1'b0;
      r_fe <= 1'b0;
      r_pv <= 1'b0;
      r_cd <= 1'b0;
      r_x  <= '0;
      r_y  <= '0;
    end else begin
      r_fs <= frame_start;
      r_fe <= frame_end;
      r_pv <= pixel_valid;
      r_cd <= corner_detected;
      r_x  <= x;
      r_y  <= y;
    end
  end

  state_e             r_state;
  logic               r_pend;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_clear, w_hit, w_first, w_enough;
  logic [XW-1:0]      w_cx [N_CORNERS];
  logic [YW-1:0]      w_cy [N_CORNERS];

  // A start seen during PUBLISH is deferred: the pending flag clears the trackers on ACCUM entry.
  always_comb begin
    w_clear  = (r_fs && r_state != ST_PUBLISH) || (r_pend && r_state == ST_ACCUM);
    w_hit    = r_pv && r_cd && (r_state == ST_ACCUM || w_clear);
    w_first  = w_hit && (w_clear || r_cnt == '0);
    w_enough = r_cnt >= CNT_W'(MIN_PIXELS);
  end

  for (genvar i = 0; i < N_CORNERS; i++) begin : g_trk
    corner_extreme_tracker #(
      .MODE (corner_mode(i)),
      .XW   (XW),
      .YW   (YW)
    ) u_trk (
      .clk          (clk),
      .i_rst        (reset),
      .i_clear      (w_clear),
      .i_hit        (w_hit),
      .i_load_first (w_first),
      .i_x          (r_x),
      .i_y          (r_y),
      .o_x          (w_cx[i]),
      .o_y          (w_cy[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)                   r_cnt <= '0;
    else if (w_clear)            r_cnt <= CNT_W'(w_hit);
    else if (w_hit && ~&r_cnt)   r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pend        <= 1'b0;
      busy          <= 1'b0;
      corners_valid <= 1'b0;
      corners_found <= 1'b0;
      tl_x <= '0; tr_x <= '0; bl_x <= '0; br_x <= '0;
      tl_y <= '0; tr_y <= '0; bl_y <= '0; br_y <= '0;
    end else begin
      corners_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_fs) begin
            r_state <= r_fe ? ST_PUBLISH : ST_ACCUM;
            busy    <= !r_fe;
          end
        end
        ST_ACCUM: begin
          r_pend <= 1'b0;
          if (r_fe) begin
            r_state <= ST_PUBLISH;
            busy    <= 1'b0;
          end
        end
        default: begin
          corners_valid <= 1'b1;
          corners_found <= w_enough;
          if (w_enough) begin
            tl_x <= w_cx[TL]; tl_y <= w_cy[TL];
            tr_x <= w_cx[TR]; tr_y <= w_cy[TR];
            bl_x <= w_cx[BL]; bl_y <= w_cy[BL];
            br_x <= w_cx[BR]; br_y <= w_cy[BR];
          end
          r_pend  <= r_fs;
          r_state <= r_fs ? ST_ACCUM : ST_IDLE;
          busy    <= r_fs;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corner_locator.sv
// Directed bench for corner_locator: hand-computed corner sets, publish timing,
// hold-on-low-count, ties, mid-frame restart and mid-frame reset.
module tb_corner_locator;
  import corner_pkg::*;

  logic       clk = 1'b0;
  logic       reset, frame_start, frame_end, pixel_valid, corner_detected;
  logic [9:0] x, y;

  logic [9:0] tl_x, tr_x, bl_x, br_x, tl_y, tr_y, bl_y, br_y;
  logic       corners_found, corners_valid, busy;
  logic [9:0] m1_tl_x, m1_tr_x, m1_bl_x, m1_br_x, m1_tl_y, m1_tr_y, m1_bl_y, m1_br_y;
  logic       m1_found, m1_valid, m1_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  corner_locator dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pixel_valid(pixel_valid), .x(x), .y(y), .corner_detected(corner_detected),
    .tl_x(tl_x), .tr_x(tr_x), .bl_x(bl_x), .br_x(br_x),
    .tl_y(tl_y), .tr_y(tr_y), .bl_y(bl_y), .br_y(br_y),
    .corners_found(corners_found), .corners_valid(corners_valid), .busy(busy)
  );

  corner_locator #(.MIN_PIXELS(1)) dut1 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pixel_valid(pixel_valid), .x(x), .y(y), .corner_detected(corner_detected),
    .tl_x(m1_tl_x), .tr_x(m1_tr_x), .bl_x(m1_bl_x), .br_x(m1_br_x),
    .tl_y(m1_tl_y), .tr_y(m1_tr_y), .bl_y(m1_bl_y), .br_y(m1_br_y),
    .corners_found(m1_found), .corners_valid(m1_valid), .busy(m1_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge and are held across one rising edge.
  task automatic cyc(input logic fs, input logic fe, input logic pv, input logic cd,
                     input int px, input int py);
    frame_start = fs; frame_end = fe; pixel_valid = pv; corner_detected = cd;
    x = 10'(px); y = 10'(py);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic hit(input int px, input int py);
    cyc(0, 0, 1, 1, px, py);
  endtask

  task automatic start_frame();
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  // Returns on the cycle where corners_valid must be high (2 cycles after frame_end).
  task automatic end_frame(input string tag);
    cyc(0, 1, 0, 0, 0, 0);
    idle();
    check({tag, "_valid_early"}, 32'(corners_valid), 0);
    idle();
    check({tag, "_valid"}, 32'(corners_valid), 1);
  endtask

  task automatic check_pub(input string tag, input corner_t e_tl, input corner_t e_tr,
                           input corner_t e_bl, input corner_t e_br, input logic e_found);
    check({tag, "_tl"}, 32'({tl_x, tl_y}), 32'(e_tl));
    check({tag, "_tr"}, 32'({tr_x, tr_y}), 32'(e_tr));
    check({tag, "_bl"}, 32'({bl_x, bl_y}), 32'(e_bl));
    check({tag, "_br"}, 32'({br_x, br_y}), 32'(e_br));
    check({tag, "_found"}, 32'(corners_found), 32'(e_found));
    idle();
    check({tag, "_valid_pulse"}, 32'(corners_valid), 0);
  endtask

  function automatic corner_t c(input int cx, input int cy);
    corner_t r;
    r.x = 10'(cx);
    r.y = 10'(cy);
    return r;
  endfunction

  initial begin
    corner_t sq_tl, sq_tr, sq_bl, sq_br, z;
    z = c(0, 0);
    reset = 1'b1;
    frame_start = 0; frame_end = 0; pixel_valid = 0; corner_detected = 0; x = '0; y = '0;
    idle(); idle();
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(corners_valid), 0);
    check_pub("rst", z, z, z, z, 1'b0);
    reset = 1'b0;
    idle();

    // Single hit: MIN_PIXELS=1 instance publishes it, default instance holds.
    start_frame();
    hit(100, 50);
    check("t1_busy", 32'(busy), 1);
    end_frame("t1");
    check("t1_m1_valid", 32'(m1_valid), 1);
    check("t1_m1_tl", 32'({m1_tl_x, m1_tl_y}), 32'(c(100, 50)));
    check("t1_m1_tr", 32'({m1_tr_x, m1_tr_y}), 32'(c(100, 50)));
    check("t1_m1_bl", 32'({m1_bl_x, m1_bl_y}), 32'(c(100, 50)));
    check("t1_m1_br", 32'({m1_br_x, m1_br_y}), 32'(c(100, 50)));
    check("t1_m1_found", 32'(m1_found), 1);
    check_pub("t1", z, z, z, z, 1'b0);
    check("t1_idle_busy", 32'(busy), 0);
    idle();

    // Filled square plus a miss and an invalid pixel that must be ignored.
    start_frame();
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int yy = 100; yy < 200; yy++)
      for (int xx = 200; xx < 300; xx++) hit(xx, yy);
    end_frame("t2");
    sq_tl = c(200, 100); sq_tr = c(299, 100); sq_bl = c(200, 199); sq_br = c(299, 199);
    check_pub("t2", sq_tl, sq_tr, sq_bl, sq_br, 1'b1);
    idle();

    // 5 hits: too few, coordinates hold.
    start_frame();
    for (int i = 0; i < 5; i++) hit(10 + i, 10);
    end_frame("t3");
    check_pub("t3", sq_tl, sq_tr, sq_bl, sq_br, 1'b0);
    idle();

    // 15 hits: one short of the threshold.
    start_frame();
    for (int i = 0; i < 15; i++) hit(20 + i, 30);
    end_frame("t4");
    check_pub("t4", sq_tl, sq_tr, sq_bl, sq_br, 1'b0);
    idle();

    // Tie on s=30: the earlier (10,20) wins TL.
    start_frame();
    for (int i = 0; i < 14; i++) hit(50 + i, 50);
    hit(10, 20);
    hit(20, 10);
    end_frame("t5");
    check_pub("t5", c(10, 20), c(63, 50), c(10, 20), c(63, 50), 1'b1);
    idle();

    // Restart mid-frame: (5,5) must be discarded; exactly 16 hits remain.
    start_frame();
    hit(5, 5);
    idle();
    start_frame();
    for (int i = 0; i < 16; i++) hit(30 + i, 40);
    end_frame("t6");
    check_pub("t6", c(30, 40), c(45, 40), c(30, 40), c(45, 40), 1'b1);
    idle();

    // frame_end while idle is ignored.
    cyc(0, 1, 0, 0, 0, 0);
    idle(); idle();
    check("t7_no_valid", 32'(corners_valid), 0);
    check("t7_busy", 32'(busy), 0);
    idle();

    // frame_start + frame_end together: one-pixel frame.
    cyc(1, 1, 1, 1, 77, 88);
    idle();
    check("t8_valid_early", 32'(m1_valid), 0);
    idle();
    check("t8_m1_valid", 32'(m1_valid), 1);
    check("t8_m1_tl", 32'({m1_tl_x, m1_tl_y}), 32'(c(77, 88)));
    check("t8_m1_br", 32'({m1_br_x, m1_br_y}), 32'(c(77, 88)));
    check_pub("t8", c(30, 40), c(45, 40), c(30, 40), c(45, 40), 1'b0);
    idle();

    // Reset mid-ACCUM, then a clean frame.
    start_frame();
    for (int i = 0; i < 3; i++) hit(1, 1);
    check("t9_busy_pre", 32'(busy), 1);
    reset = 1'b1;
    idle();
    check("t9_busy_rst", 32'(busy), 0);
    check_pub("t9_rst", z, z, z, z, 1'b0);
    reset = 1'b0;
    idle();
    start_frame();
    for (int i = 0; i < 16; i++) hit(400 + i, 300 + i);
    end_frame("t10");
    check_pub("t10", c(400, 300), c(400, 300), c(400, 300), c(415, 315), 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
